// File: rtl/mm_pkg.sv
// Shared definitions for the main-memory burst responder, cache controller
// and cache-line buffer.
package mm_pkg;

   localparam int unsigned MM_WORD_W         = 32;
   localparam int unsigned MM_WORDS_PER_LINE = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READ_BURST,
      S_WRITE_BURST
   } mm_state_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mm_sram.sv
// Single-port backing store: synchronous write, asynchronous read, no reset.
module mm_sram
   import mm_pkg::*;
#(
   parameter int unsigned WORD_W = MM_WORD_W,
   parameter int unsigned DEPTH  = 16384,
   parameter int unsigned AW     = clog2_min1(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Write port: one word per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mm_burst_responder.sv
// Main-memory model answering cache-line read and write bursts.
// MM_LATENCY_EN: when defined, a WAIT phase of LATENCY cycles precedes the
// first beat; when undefined the first beat follows the request directly.
module mm_burst_responder
   import mm_pkg::*;
#(
   parameter int unsigned WORD_W         = MM_WORD_W,
   parameter int unsigned WORDS_PER_LINE = MM_WORDS_PER_LINE,
   parameter int unsigned DEPTH          = 16384,
   parameter int unsigned LATENCY        = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              re_mm,
   input  logic              we_mm,
   input  logic [31:0]       addr_mm,
   input  logic [WORD_W-1:0] wdata_mm,
   output logic [WORD_W-1:0] rdata_mm,
   output logic              mem_valid_mm,
   output logic              busy
);

   localparam int unsigned AW     = clog2_min1(DEPTH);
   localparam int unsigned BEAT_W = clog2_min1(WORDS_PER_LINE);
`ifdef MM_LATENCY_EN
   localparam int unsigned LAT_EFF = LATENCY;
`else
   // Latency parameter is accepted for interface compatibility but has no effect.
   localparam int unsigned LAT_EFF = 0 * LATENCY;
`endif
   localparam int unsigned LAT_W    = clog2_min1(LAT_EFF);
   localparam int unsigned LAT_LOAD = (LAT_EFF > 0) ? LAT_EFF - 1 : 0;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   mm_state_t         state, state_d;
   logic [BEAT_W-1:0] beat, beat_d;
   logic [LAT_W-1:0]  lat_cnt, lat_d;
   logic [31:0]       base, base_d;
   logic              dir_wr, dir_wr_d;

   logic [31:0]       req_word;
   logic [31:0]       beat_sum;
   logic [AW-1:0]     mem_addr;
   logic              sram_we;
   logic              rd_sel;
   logic [WORD_W-1:0] sram_rdata;

   // Word address of the current beat, wrapping inside the store.
   assign req_word = addr_mm >> 2;
   assign beat_sum = base + 32'(beat);
   assign mem_addr = AW'(beat_sum % DEPTH);

   // State and burst-context registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         beat    <= '0;
         lat_cnt <= '0;
         base    <= '0;
         dir_wr  <= 1'b0;
      end else begin
         state   <= state_d;
         beat    <= beat_d;
         lat_cnt <= lat_d;
         base    <= base_d;
         dir_wr  <= dir_wr_d;
      end
   end

   // Next-state and per-beat strobes; a dropped request aborts in the same cycle.
   always_comb begin
      state_d      = state;
      beat_d       = beat;
      lat_d        = lat_cnt;
      base_d       = base;
      dir_wr_d     = dir_wr;
      mem_valid_mm = 1'b0;
      busy         = 1'b1;
      sram_we      = 1'b0;
      rd_sel       = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (we_mm || re_mm) begin
               base_d   = req_word - (req_word % WORDS_PER_LINE);
               beat_d   = '0;
               dir_wr_d = we_mm;
               if (LAT_EFF > 0) begin
                  state_d = S_WAIT;
                  lat_d   = LAT_W'(LAT_LOAD);
               end else begin
                  state_d = we_mm ? S_WRITE_BURST : S_READ_BURST;
               end
            end
         end
         S_WAIT: begin
            if (!(dir_wr ? we_mm : re_mm)) begin
               state_d = S_IDLE;
            end else if (lat_cnt == '0) begin
               state_d = dir_wr ? S_WRITE_BURST : S_READ_BURST;
            end else begin
               lat_d = lat_cnt - LAT_W'(1);
            end
         end
         S_READ_BURST: begin
            rd_sel = 1'b1;
            if (re_mm) begin
               mem_valid_mm = 1'b1;
               beat_d       = beat + BEAT_W'(1);
               if (beat == LAST_BEAT) begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE_BURST: begin
            if (we_mm) begin
               mem_valid_mm = 1'b1;
               sram_we      = 1'b1;
               beat_d       = beat + BEAT_W'(1);
               if (beat == LAST_BEAT) begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rdata_mm = rd_sel ? sram_rdata : '0;

   mm_sram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .addr  (mem_addr),
      .wdata (wdata_mm),
      .rdata (sram_rdata)
   );

endmodule

// File: tb/tb_mm_burst_responder.sv
// Scoreboard bench for mm_burst_responder: the driver queues expected beats
// from a word-level memory model, a negedge monitor pops and compares them.
module tb_mm_burst_responder;

   localparam int unsigned WPL   = 4;
   localparam int unsigned DEPTH = 16384;
`ifdef MM_LATENCY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int          cyc;
      bit          wr;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        re_mm;
   logic        we_mm;
   logic [31:0] addr_mm;
   logic [31:0] wdata_mm;
   logic [31:0] rdata_mm;
   logic        mem_valid_mm;
   logic        busy;

   int          cyc;
   int          n_checks;
   int          n_pass;
   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] wbuf [WPL];

   mm_burst_responder #(
      .WORD_W         (32),
      .WORDS_PER_LINE (WPL),
      .DEPTH          (DEPTH),
      .LATENCY        (3)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .re_mm        (re_mm),
      .we_mm        (we_mm),
      .addr_mm      (addr_mm),
      .wdata_mm     (wdata_mm),
      .rdata_mm     (rdata_mm),
      .mem_valid_mm (mem_valid_mm),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Store word touched by beat i of a line request at byte address a.
   function automatic int unsigned widx(input logic [31:0] a, input int unsigned i);
      int unsigned w;
      w = 32'(a >> 2);
      w = w - (w % WPL);
      return (w + i) % DEPTH;
   endfunction

   function automatic bit line_known(input logic [31:0] a);
      for (int i = 0; i < WPL; i++) begin
         if (!ref_mem.exists(widx(a, i))) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < WPL; i++) wbuf[i] = $urandom;
   endtask

   // One line request of nb beats (nb < WPL aborts); entered and left at #1 after posedge.
   task automatic burst(input bit wr, input bit rd, input logic [31:0] a, input int nb,
                        input bit chain);
      int   k;
      exp_t e;
      chk("idle_at_request", busy, 0);
      k        = cyc;
      we_mm    = wr;
      re_mm    = rd;
      addr_mm  = a;
      wdata_mm = $urandom;
      for (int i = 0; i < nb; i++) begin
         e.cyc = k + 1 + LAT + i;
         e.wr  = wr;
         if (wr) begin
            e.data = wbuf[i];
            ref_mem[widx(a, i)] = wbuf[i];
         end else begin
            e.data = ref_mem[widx(a, i)];
         end
         sbq.push_back(e);
      end
      for (int t = 1; t <= LAT + nb; t++) begin
         @(posedge clk); #1;
         if (t > LAT) wdata_mm = wbuf[t - 1 - LAT];
         else chk("busy_in_wait", busy, 1);
      end
      @(posedge clk); #1;
      if (!chain) begin
         we_mm    = 1'b0;
         re_mm    = 1'b0;
         wdata_mm = $urandom;
      end
      if (nb < WPL) begin
         @(posedge clk); #1;
      end else if (!chain) begin
         chk("busy_after_burst", busy, 0);
      end
   endtask

   // Write two beats, then pulse reset while the third beat is presented.
   task automatic reset_mid_write(input logic [31:0] a);
      int   k;
      exp_t e;
      k       = cyc;
      we_mm   = 1'b1;
      addr_mm = a;
      for (int i = 0; i < 2; i++) begin
         e.cyc  = k + 1 + LAT + i;
         e.wr   = 1'b1;
         e.data = wbuf[i];
         ref_mem[widx(a, i)] = wbuf[i];
         sbq.push_back(e);
      end
      for (int t = 1; t <= LAT + 2; t++) begin
         @(posedge clk); #1;
         if (t > LAT) wdata_mm = wbuf[t - 1 - LAT];
      end
      @(posedge clk); #1;
      wdata_mm = wbuf[2];
      chk("valid_before_reset", mem_valid_mm, 1);
      reset_n = 1'b0;
      #1;
      chk("reset_valid", mem_valid_mm, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rdata", rdata_mm, 0);
      we_mm = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_valid_mm) begin
            if (sbq.size() == 0) begin
               chk("unexpected_beat", mem_valid_mm, 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
               chk("busy_on_beat", busy, 1);
               if (mon_e.wr) chk("rdata_on_write", rdata_mm, 0);
               else          chk("rdata", rdata_mm, mon_e.data);
            end
         end else if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
            chk("missing_beat", mem_valid_mm, 1);
            mon_e = sbq.pop_front();
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int unsigned line;
      int unsigned op;
      bit          ch;
      cyc      = 0;
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      re_mm    = 1'b0;
      we_mm    = 1'b0;
      addr_mm  = '0;
      wdata_mm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", mem_valid_mm, 0);
      chk("rst_rdata", rdata_mm, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Known pattern write then read back.
      for (int i = 0; i < WPL; i++) wbuf[i] = 32'hA0 + 32'(i);
      burst(1, 0, 32'h100, WPL, 0);
      burst(0, 1, 32'h100, WPL, 0);

      // Read latency on a fresh line.
      fill_rand();
      burst(1, 0, 32'h200, WPL, 0);
      burst(0, 1, 32'h200, WPL, 0);

      // Simultaneous write and read request: write wins.
      fill_rand();
      burst(1, 0, 32'h300, WPL, 0);
      for (int i = 0; i < WPL; i++) wbuf[i] = 32'hC0 + 32'(i);
      burst(1, 1, 32'h300, WPL, 0);
      burst(0, 1, 32'h300, WPL, 0);

      // Writeback followed back-to-back by a refill.
      fill_rand();
      burst(1, 0, 32'h500, WPL, 0);
      fill_rand();
      burst(1, 0, 32'h400, WPL, 1);
      burst(0, 1, 32'h500, WPL, 0);
      burst(0, 1, 32'h400, WPL, 0);

      // Read aborted after two beats, then a full read.
      burst(0, 1, 32'h100, 2, 0);
      burst(0, 1, 32'h100, WPL, 0);

      // Reset in the middle of a write burst keeps the written beats.
      fill_rand();
      burst(1, 0, 32'h600, WPL, 0);
      fill_rand();
      reset_mid_write(32'h600);
      burst(0, 1, 32'h600, WPL, 0);

      // Randomised traffic over a few lines, including wrapped and unaligned addresses.
      for (int n = 0; n < 40; n++) begin
         line = $urandom_range(0, 7);
         a    = 32'(32'h1000 + line * 16 + ($urandom_range(0, 1) != 0 ? DEPTH * 4 : 0)
                    + $urandom_range(0, 15));
         op   = $urandom_range(0, 3);
         ch   = (n < 39) && ($urandom_range(0, 3) == 0);
         fill_rand();
         case (op)
            0: burst(1, 0, a, WPL, ch);
            1: if (line_known(a)) burst(0, 1, a, WPL, ch);
               else               burst(1, 0, a, WPL, ch);
            2: burst(1, 1, a, WPL, ch);
            default: if (line_known(a)) burst(0, 1, a, int'($urandom_range(1, WPL - 1)), 1'b0);
                     else               burst(1, 0, a, int'($urandom_range(1, WPL - 1)), 1'b0);
         endcase
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(sbq.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
